// File: rtl/uart_tx_queue.sv
// uart_tx_queue: byte FIFO feeding a UART transmitter through a start/ack/done dispatch FSM
module uart_tx_queue #(
  parameter int DEPTH = 16,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          overflow,
  input  logic          tx_busy,
  output logic [7:0]    tx_data,
  output logic          tx_start
);
  localparam logic [1:0] IDLE = 2'd0, START = 2'd1, WAIT_ACK = 2'd2, WAIT_DONE = 2'd3;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [1:0] state, state_nx;
  logic [3:0] tmo;
  logic wr_ok, pop;
  logic [AW:0] count_nx;
  assign wr_ok = wr_en && !full;
  assign pop = state == IDLE && !empty && !tx_busy;
  assign count_nx = count + {{AW{1'b0}}, wr_ok} - {{AW{1'b0}}, pop};
  assign tx_start = state == START;
  // tmo==15 on the 16th idle WAIT_ACK cycle, so retries recur every 17 cycles
  always_comb
    state_nx = state == IDLE     ? (pop ? START : IDLE) :
               state == START    ? WAIT_ACK :
               state == WAIT_ACK ? (tx_busy ? WAIT_DONE : (tmo == 4'd15 ? START : WAIT_ACK)) :
                                   (tx_busy ? WAIT_DONE : IDLE);
  always_ff @(posedge clk)
    if (wr_ok) mem[wr_ptr] <= wr_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
      tx_data  <= 8'h00;
      state    <= IDLE;
      tmo      <= 4'd0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        tx_data <= mem[rd_ptr];
      end
      if (wr_en && full) overflow <= 1'b1;
      count <= count_nx;
      full  <= count_nx == FULL_CNT;
      empty <= count_nx == '0;
      tmo   <= state == WAIT_ACK ? tmo + 4'd1 : 4'd0;
      state <= state_nx;
    end
  end
endmodule
